// File: rtl/dvp_capture_ctrl.sv
// Purpose: frame-gating capture controller between the DVP byte receiver and video DMA;
//          aligns to frame boundaries, skips warm-up frames, regenerates AXI-S tuser/tlast.
// Latency: 1 cycle from accepted s_* byte to m_* byte.
// Backpressure: none; m_tready cannot stall the source, so a stall is only recorded in sticky overflow.
//
// Ports:
//   pclk, rst                         : pixel clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast          : receiver byte stream, s_tlast = last byte of frame
//   start/stop                        : one-cycle control pulses
//   continuous/skip_frames            : capture mode, sampled on start
//   m_tdata/m_tvalid/m_tuser/m_tlast  : AXI-S video out (tuser = SOF, tlast = EOL)
//   m_tready                          : downstream ready, observed only for overflow
//   busy/frame_done/frame_cnt         : status
//   frame_err/overflow                : sticky errors, cleared on start
module dvp_capture_ctrl #(
    parameter int LINE_BYTES = 1280,
    parameter int LINES      = 480,
    parameter int X_W        = 11,
    parameter int Y_W        = 10
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    input  logic [3:0]  skip_frames,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tuser,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        frame_err,
    output logic        overflow
);

    localparam logic [X_W-1:0] X_LAST = X_W'(LINE_BYTES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(LINES - 1);

    typedef enum logic [1:0] {IDLE, SYNC, SKIP, CAPTURE} state_t;

    state_t         state, state_nxt;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [3:0]     skip_cnt;
    logic           stop_pending;
    logic           cont_mode;
    // Set once the final byte of the nominal frame has been forwarded;
    // everything after that up to s_tlast belongs to an over-long frame.
    logic           full;

    logic           fwd;        // forward current input byte
    logic           frame_end;  // s_tlast accepted while capturing
    logic           arm;        // start accepted in IDLE
    logic           eof_in;

    assign eof_in = s_tvalid && s_tlast;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        frame_end = 1'b0;
        arm       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    arm       = 1'b1;
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (stop)
                    state_nxt = IDLE;
                else if (eof_in)
                    state_nxt = (skip_cnt != 4'd0) ? SKIP : CAPTURE;
            end
            SKIP: begin
                if (stop)
                    state_nxt = IDLE;
                else if (eof_in && skip_cnt <= 4'd1)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (s_tvalid) begin
                    fwd = !full;
                    if (s_tlast) begin
                        frame_end = 1'b1;
                        // stop seen in the same cycle as s_tlast still ends capture
                        if (!cont_mode || stop_pending || stop)
                            state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            full         <= 1'b0;
            skip_cnt     <= 4'd0;
            stop_pending <= 1'b0;
            cont_mode    <= 1'b0;
            m_tdata      <= 8'd0;
            m_tvalid     <= 1'b0;
            m_tuser      <= 1'b0;
            m_tlast      <= 1'b0;
            frame_done   <= 1'b0;
            frame_cnt    <= 16'd0;
            frame_err    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_end;
            m_tvalid   <= fwd;
            m_tuser    <= fwd && (x == '0) && (y == '0);
            // an early s_tlast truncates the line, so it also closes it
            m_tlast    <= fwd && ((x == X_LAST) || s_tlast);
            if (fwd)
                m_tdata <= s_tdata;

            // overflow watches the registered output that downstream actually sees
            if (arm)
                overflow <= 1'b0;
            else if (m_tvalid && !m_tready)
                overflow <= 1'b1;

            if (arm) begin
                cont_mode    <= continuous;
                skip_cnt     <= skip_frames;
                frame_cnt    <= 16'd0;
                frame_err    <= 1'b0;
                stop_pending <= 1'b0;
                x            <= '0;
                y            <= '0;
                full         <= 1'b0;
            end

            if (state == SKIP && eof_in)
                skip_cnt <= skip_cnt - 4'd1;

            if (state == CAPTURE && stop)
                stop_pending <= 1'b1;
            if (state != IDLE && state_nxt == IDLE)
                stop_pending <= 1'b0;

            if (state == CAPTURE && s_tvalid) begin
                if (s_tlast) begin
                    x         <= '0;
                    y         <= '0;
                    full      <= 1'b0;
                    frame_cnt <= frame_cnt + 16'd1;
                    if (full || x != X_LAST || y != Y_LAST)
                        frame_err <= 1'b1;
                end else if (full) begin
                    frame_err <= 1'b1;
                end else if (x == X_LAST) begin
                    x <= '0;
                    if (y == Y_LAST)
                        full <= 1'b1;
                    else
                        y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Purpose: directed self-checking bench for dvp_capture_ctrl with 4-byte lines, 3-line frames.
// Latency: expects each forwarded byte on m_* one cycle after it is driven.
// Backpressure: m_tready is dropped briefly to provoke the sticky overflow flag.
module tb_dvp_capture_ctrl;

    localparam int LB = 4;
    localparam int LN = 3;

    logic        pclk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [3:0]  skip_frames;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tready;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        frame_err;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [9:0] outq[$];   // {tuser, tlast, tdata}

    dvp_capture_ctrl #(.LINE_BYTES(LB), .LINES(LN), .X_W(2), .Y_W(2)) dut (
        .pclk(pclk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .start(start), .stop(stop), .continuous(continuous), .skip_frames(skip_frames),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tready(m_tready), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (m_tvalid) outq.push_back({m_tuser, m_tlast, m_tdata});
        if (frame_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_start(input logic cont, input logic [3:0] skip);
        start       = 1'b1;
        continuous  = cont;
        skip_frames = skip;
        step();
        start = 1'b0;
    endtask

    // Drive one n-byte frame plus a one-cycle gap. stop pulses on byte stop_at;
    // m_tready is low while bytes bp_at and bp_at+1 are driven.
    task automatic send_frame(input int n, input int stop_at, input int bp_at);
        for (int i = 0; i < n; i++) begin
            s_tdata  = 8'(i);
            s_tvalid = 1'b1;
            s_tlast  = (i == n - 1);
            stop     = (i == stop_at);
            m_tready = !(i == bp_at || i == bp_at + 1);
            step();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        stop     = 1'b0;
        m_tready = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Compare n_fwd queued bytes starting at base against a frame of n_src source bytes.
    task automatic check_frame(input string tag, input int base, input int n_fwd, input int n_src);
        logic [9:0] exp;
        for (int i = 0; i < n_fwd; i++) begin
            exp = {(i == 0), ((i % LB) == LB - 1) || (i == n_src - 1), 8'(i)};
            if (base + i < outq.size())
                chk($sformatf("%s_b%0d", tag, i), 32'(outq[base + i]), 32'(exp));
            else
                chk($sformatf("%s_b%0d_missing", tag, i), 32'hFFFF_FFFF, 32'(exp));
        end
    endtask

    initial begin
        rst = 1'b1; s_tdata = 8'd0; s_tvalid = 1'b0; s_tlast = 1'b0;
        start = 1'b0; stop = 1'b0; continuous = 1'b0; skip_frames = 4'd0; m_tready = 1'b1;
        idle(3);
        @(negedge pclk);
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tuser", 32'(m_tuser), 0);
        chk("rst_tlast", 32'(m_tlast), 0);
        chk("rst_tdata", 32'(m_tdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        step();

        // basic single capture
        outq.delete(); done_cnt = 0;
        do_start(1'b0, 4'd0);
        chk("basic_busy_on", 32'(busy), 1);
        send_frame(12, -1, -1);
        chk("basic_sync_drop", 32'(outq.size()), 0);
        send_frame(12, -1, -1);
        send_frame(12, -1, -1);
        idle(2);
        chk("basic_count", 32'(outq.size()), 12);
        check_frame("basic", 0, 12, 12);
        chk("basic_done", 32'(done_cnt), 1);
        chk("basic_cnt", 32'(frame_cnt), 1);
        chk("basic_busy_off", 32'(busy), 0);
        chk("basic_err", 32'(frame_err), 0);

        // skip two, continuous, stop mid fifth frame
        outq.delete(); done_cnt = 0;
        do_start(1'b1, 4'd2);
        send_frame(12, -1, -1);
        send_frame(12, -1, -1);
        send_frame(12, -1, -1);
        chk("skip_nothing_yet", 32'(outq.size()), 0);
        send_frame(12, -1, -1);
        chk("skip_first_capt", 32'(outq.size()), 12);
        send_frame(12, 5, -1);
        chk("skip_busy_off", 32'(busy), 0);
        send_frame(12, -1, -1);
        idle(2);
        chk("skip_count", 32'(outq.size()), 24);
        check_frame("skip_f4", 0, 12, 12);
        check_frame("skip_f5", 12, 12, 12);
        chk("skip_cnt", 32'(frame_cnt), 2);
        chk("skip_done", 32'(done_cnt), 2);

        // short frame
        outq.delete(); done_cnt = 0;
        do_start(1'b0, 4'd0);
        send_frame(12, -1, -1);
        send_frame(10, -1, -1);
        idle(2);
        chk("short_count", 32'(outq.size()), 10);
        check_frame("short", 0, 10, 10);
        chk("short_err", 32'(frame_err), 1);
        chk("short_done", 32'(done_cnt), 1);

        // long frame
        outq.delete(); done_cnt = 0;
        do_start(1'b0, 4'd0);
        @(negedge pclk);
        chk("long_err_cleared", 32'(frame_err), 0);
        step();
        send_frame(12, -1, -1);
        send_frame(14, -1, -1);
        idle(2);
        chk("long_count", 32'(outq.size()), 12);
        check_frame("long", 0, 12, 14);
        chk("long_err", 32'(frame_err), 1);
        chk("long_cnt", 32'(frame_cnt), 1);
        do_start(1'b0, 4'd0);
        @(negedge pclk);
        chk("long_restart_err", 32'(frame_err), 0);
        chk("long_restart_cnt", 32'(frame_cnt), 0);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("sync_stop_idle", 32'(busy), 0);

        // backpressure
        outq.delete(); done_cnt = 0;
        do_start(1'b0, 4'd0);
        chk("bp_ovf_clear", 32'(overflow), 0);
        send_frame(12, -1, -1);
        send_frame(12, -1, 5);
        idle(4);
        chk("bp_overflow", 32'(overflow), 1);
        chk("bp_count", 32'(outq.size()), 12);
        check_frame("bp", 0, 12, 12);

        // reset mid-capture at byte 5
        outq.delete(); done_cnt = 0;
        do_start(1'b1, 4'd0);
        send_frame(12, -1, -1);
        for (int i = 0; i < 5; i++) begin
            s_tdata = 8'(i); s_tvalid = 1'b1; s_tlast = 1'b0;
            step();
        end
        s_tdata = 8'd5; rst = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        chk("mrst_outs", 32'({m_tvalid, m_tuser, m_tlast, m_tdata, busy, frame_done}), 0);
        chk("mrst_stat", 32'({frame_cnt, frame_err, overflow}), 0);
        outq.delete(); done_cnt = 0;
        rst = 1'b0; s_tdata = 8'd6;
        step();
        s_tdata = 8'd7; start = 1'b1; continuous = 1'b0; skip_frames = 4'd0;
        step();
        start = 1'b0;
        for (int i = 8; i < 12; i++) begin
            s_tdata = 8'(i); s_tlast = (i == 11);
            step();
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        step();
        chk("mrst_no_partial", 32'(outq.size()), 0);
        send_frame(12, -1, -1);
        idle(2);
        chk("mrst_count", 32'(outq.size()), 12);
        check_frame("mrst", 0, 12, 12);
        chk("mrst_cnt", 32'(frame_cnt), 1);
        chk("mrst_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
